// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU: opcode encodings, NZCV flag layout, FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Ports: none (package).
package alu_pkg;

  // Opcode encodings; 4'b1011..4'b1111 are reserved and flagged as illegal.
  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_NOT = 4'b0010,
    OP_AND = 4'b0011,
    OP_OR  = 4'b0100,
    OP_XOR = 4'b0101,
    OP_ASL = 4'b0110,
    OP_LSL = 4'b0111,
    OP_ASR = 4'b1000,
    OP_LSR = 4'b1001,
    OP_MUL = 4'b1010
  } alu_op_e;

  // Bit positions of each flag inside the 4-bit flags bus {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_MUL_BUSY = 1'b1
  } alu_state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: one partial product per clock edge, WIDTH edges in total.
// Latency: start edge handles multiplier bit 0; done is high in the cycle whose edge adds bit WIDTH-1.
// Backpressure: none; the parent only pulses start when it can absorb the product on done.
// Ports: clk, rst_n (sync, active-low, aborts a run), start, a/b (sampled on start),
//        done (combinational, valid with product), product[2*WIDTH-1:0].
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy_q,   busy_d;
  logic [CW-1:0]      cnt_q,    cnt_d;
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  logic [2*WIDTH-1:0] mcand_q,  mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] pp;

  // product already includes the partial product of the current cycle, so on the
  // last cycle the parent can take the full result at the same edge.
  always_comb begin
    pp      = mplier_q[0] ? mcand_q : '0;
    product = acc_q + pp;
    done    = busy_q && (cnt_q == CW'(WIDTH - 1));

    busy_d   = busy_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;

    if (start) begin
      // Bit 0 is folded into the start edge so the whole run takes WIDTH edges.
      busy_d   = 1'b1;
      cnt_d    = CW'(1);
      acc_d    = b[0] ? {{WIDTH{1'b0}}, a} : '0;
      mcand_d  = {{(WIDTH-1){1'b0}}, a, 1'b0};
      mplier_d = b >> 1;
    end else if (busy_q) begin
      acc_d    = product;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CW'(1);
      if (done) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake and a persistent NZCV flag register.
// Latency: non-MUL ops load on the accepting edge; MUL loads on the WIDTH-th edge counting that one.
// Backpressure: held result stalls input (in_ready=0); a drain and a new accept may share one edge.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/a/b/op (input handshake),
//        out_valid/out_ready/result/flags{N,Z,C,V}/illegal_op (output handshake).
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             illegal_op
);

  localparam int              AW    = $clog2(WIDTH);
  localparam int              MSB   = WIDTH - 1;
  localparam logic [WIDTH-1:0] W_MOD = WIDTH'(WIDTH);

  alu_state_e         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  alu_flags_t         flags_q, flags_d;
  logic               illegal_q, illegal_d;

  alu_op_e            op_e;
  logic               accept;
  logic               is_mul;
  logic [AW-1:0]      amt;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w, asr_w;
  logic               asl_v;
  logic [WIDTH-1:0]   dp_res;
  logic               dp_c, dp_v, dp_ill;

  logic               mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  logic               load;
  logic [WIDTH-1:0]   ld_res;
  logic               ld_c, ld_v, ld_ill;

  assign op_e     = alu_op_e'(op);
  assign in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (op_e == OP_MUL) && MUL_EN;

  // Shift amount is b modulo WIDTH (a plain bit slice when WIDTH is a power of two).
  assign amt = AW'(b % W_MOD);

  // One extra bit on each shift captures the last bit shifted out (0 when amt==0).
  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  assign shl_w = {1'b0, a} << amt;
  assign shr_w = {a, 1'b0} >> amt;
  assign asr_w = $signed({a, 1'b0}) >>> amt;

  // ASL overflows when any bit shifted through the sign position differs from the sign.
  always_comb begin
    asl_v = 1'b0;
    for (int i = 1; i < WIDTH; i++) begin
      if ((i <= int'(amt)) && (a[MSB-i] != a[MSB])) asl_v = 1'b1;
    end
  end

  // Single-cycle datapath; MUL results come from the multiplier instead.
  always_comb begin
    dp_res = '0;
    dp_c   = 1'b0;
    dp_v   = 1'b0;
    dp_ill = 1'b0;
    case (op_e)
      OP_ADD: begin
        dp_res = add_w[MSB:0];
        dp_c   = add_w[WIDTH];
        dp_v   = (a[MSB] == b[MSB]) && (add_w[MSB] != a[MSB]);
      end
      OP_SUB: begin
        dp_res = sub_w[MSB:0];
        dp_c   = sub_w[WIDTH];  // 1 = no borrow
        dp_v   = (a[MSB] != b[MSB]) && (sub_w[MSB] != a[MSB]);
      end
      OP_NOT: dp_res = ~a;
      OP_AND: dp_res = a & b;
      OP_OR:  dp_res = a | b;
      OP_XOR: dp_res = a ^ b;
      OP_ASL: begin
        dp_res = shl_w[MSB:0];
        dp_c   = shl_w[WIDTH];
        dp_v   = asl_v;
      end
      OP_LSL: begin
        dp_res = shl_w[MSB:0];
        dp_c   = shl_w[WIDTH];
      end
      OP_ASR: begin
        dp_res = asr_w[WIDTH:1];
        dp_c   = asr_w[0];
      end
      OP_LSR: begin
        dp_res = shr_w[WIDTH:1];
        dp_c   = shr_w[0];
      end
      OP_MUL: dp_ill = !MUL_EN;
      default: dp_ill = 1'b1;
    endcase
  end

  // FSM next state and output-register load selection.
  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    load      = 1'b0;
    ld_res    = dp_res;
    ld_c      = dp_c;
    ld_v      = dp_v;
    ld_ill    = dp_ill;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = S_MUL_BUSY;
          end else begin
            load = 1'b1;
          end
        end
      end
      S_MUL_BUSY: begin
        if (mul_done) begin
          load    = 1'b1;
          ld_res  = mul_product[MSB:0];
          ld_c    = |mul_product[2*WIDTH-1:WIDTH];
          ld_v    = 1'b0;
          ld_ill  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Output register: holds under backpressure, flags persist past the transfer.
    out_valid_d = out_valid_q && !out_ready;
    result_d    = result_q;
    flags_d     = flags_q;
    illegal_d   = illegal_q;
    if (load) begin
      out_valid_d = 1'b1;
      result_d    = ld_res;
      flags_d.n   = ld_res[MSB];
      flags_d.z   = (ld_res == '0);
      flags_d.c   = ld_c;
      flags_d.v   = ld_v;
      illegal_d   = ld_ill;
    end
  end

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_start),
        .a       (a),
        .b       (b),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      flags_q     <= flags_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign flags      = flags_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq (WIDTH=8, MUL_EN=1): directed vectors with literal expectations,
// plus a transaction-level reference model compared against the DUT every cycle.
module tb_alu_seq;

  localparam int     W     = 8;
  localparam longint FULL  = longint'(1) << W;
  localparam longint HALF  = FULL / 2;
  localparam longint MASK  = FULL - 1;
  localparam longint SMAX  = HALF - 1;
  localparam longint SMIN  = -HALF;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [3:0]   flags;
  logic         illegal_op;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic [3:0]   flg;
    logic         ill;
  } exp_t;

  // Reference model state.
  int           m_mul_left = 0;
  logic         m_ov       = 1'b0;
  logic [W-1:0] m_res      = '0;
  logic [3:0]   m_flg      = '0;
  logic         m_ill      = 1'b0;
  logic         m_started  = 1'b0;
  exp_t         m_pend     = '0;

  alu_seq #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .op         (op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .flags      (flags),
    .illegal_op (illegal_op)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Arithmetic reference: integer maths on signed/unsigned interpretations.
  function automatic exp_t ref_alu(input logic [3:0] opc, input logic [W-1:0] av,
                                   input logic [W-1:0] bv);
    exp_t   e;
    longint ua, ub, sa, sb, r, full, s;
    int     amt;
    logic   c, v;
    ua  = longint'(av);
    ub  = longint'(bv);
    sa  = (ua >= HALF) ? ua - FULL : ua;
    sb  = (ub >= HALF) ? ub - FULL : ub;
    amt = int'(ub % W);
    r = 0; c = 1'b0; v = 1'b0; e = '0;
    case (opc)
      4'd0: begin full = ua + ub; r = full & MASK; c = (full > MASK);
                  s = sa + sb; v = (s > SMAX) || (s < SMIN); end
      4'd1: begin r = (ua - ub) & MASK; c = (ua >= ub);
                  s = sa - sb; v = (s > SMAX) || (s < SMIN); end
      4'd2: r = ~ua & MASK;
      4'd3: r = ua & ub;
      4'd4: r = ua | ub;
      4'd5: r = ua ^ ub;
      4'd6, 4'd7: begin
        r = (ua << amt) & MASK;
        c = (amt != 0) && (((ua >> (W - amt)) & 1) != 0);
        if (opc == 4'd6) begin
          s = sa * (longint'(1) << amt);
          v = (s > SMAX) || (s < SMIN);
        end
      end
      4'd8: begin r = (sa >>> amt) & MASK; c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      4'd9: begin r = ua >> amt;           c = (amt != 0) && (((ua >> (amt - 1)) & 1) != 0); end
      4'd10: begin full = ua * ub; r = full & MASK; c = ((full >> W) != 0); end
      default: begin r = 0; e.ill = 1'b1; end
    endcase
    e.res = r[W-1:0];
    e.flg = {r[W-1], (r == 0), c, v};
    return e;
  endfunction

  // Model advances on each rising edge using the inputs the DUT sees.
  initial forever begin
    logic rdy;
    exp_t e;
    @(posedge clk);
    rdy = (m_mul_left == 0) && (!m_ov || out_ready);
    m_started = 1'b1;
    if (!rst_n) begin
      m_mul_left = 0;
      m_ov = 1'b0; m_res = '0; m_flg = '0; m_ill = 1'b0;
    end else begin
      if (m_ov && out_ready) m_ov = 1'b0;
      if (m_mul_left > 0) begin
        m_mul_left--;
        if (m_mul_left == 0) begin
          m_ov = 1'b1; m_res = m_pend.res; m_flg = m_pend.flg; m_ill = m_pend.ill;
        end
      end else if (in_valid && rdy) begin
        e = ref_alu(op, a, b);
        if (op == 4'd10) begin
          m_mul_left = W - 1;  // accepting edge is the first of W
          m_pend     = e;
        end else begin
          m_ov = 1'b1; m_res = e.res; m_flg = e.flg; m_ill = e.ill;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    #1;
    if (m_started) begin
      chk("cmp_in_ready",  32'(in_ready),   32'((m_mul_left == 0) && (!m_ov || out_ready)));
      chk("cmp_out_valid", 32'(out_valid),  32'(m_ov));
      chk("cmp_result",    32'(result),     32'(m_res));
      chk("cmp_flags",     32'(flags),      32'(m_flg));
      chk("cmp_illegal",   32'(illegal_op), 32'(m_ill));
    end
  end

  // Offer one op, wait for acceptance and the result, then check literal expectations.
  // Called at negedge+2; returns at negedge+2 of the cycle where out_valid is first seen.
  task automatic run_vec(input string nm, input logic [3:0] op_v, input logic [W-1:0] a_v,
                         input logic [W-1:0] b_v, input logic [W-1:0] e_res,
                         input logic [3:0] e_flg, input logic e_ill, input int e_lat);
    int guard;
    int lat;
    in_valid = 1'b1; op = op_v; a = a_v; b = b_v;
    #1;
    guard = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clk); #2; guard++;
    end
    chk({nm, "_accept_timeout"}, 32'(guard >= 100), 32'(0));
    @(negedge clk);
    in_valid = 1'b0; op = 4'd0; a = '0; b = '0;
    #2;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk); #2; lat++;
    end
    chk({nm, "_latency"}, 32'(lat),        32'(e_lat));
    chk({nm, "_result"},  32'(result),     32'(e_res));
    chk({nm, "_flags"},   32'(flags),      32'(e_flg));
    chk({nm, "_illegal"}, 32'(illegal_op), 32'(e_ill));
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 4'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #2;
    chk("reset_out_valid", 32'(out_valid),  32'(0));
    chk("reset_result",    32'(result),     32'(0));
    chk("reset_flags",     32'(flags),      32'(0));
    chk("reset_illegal",   32'(illegal_op), 32'(0));
    chk("reset_in_ready",  32'(in_ready),   32'(1));

    //             name        op       a      b      res    NZCV     ill  lat
    run_vec("add_ff_01",  4'b0000, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0, 1);
    run_vec("sub_05_07",  4'b0001, 8'h05, 8'h07, 8'hFE, 4'b1000, 1'b0, 1);
    run_vec("sub_80_01",  4'b0001, 8'h80, 8'h01, 8'h7F, 4'b0011, 1'b0, 1);
    run_vec("mul_0c_0b",  4'b1010, 8'h0C, 8'h0B, 8'h84, 4'b1000, 1'b0, W);
    run_vec("mul_20_10",  4'b1010, 8'h20, 8'h10, 8'h00, 4'b0110, 1'b0, W);
    run_vec("mul_ff_ff",  4'b1010, 8'hFF, 8'hFF, 8'h01, 4'b0010, 1'b0, W);
    run_vec("asr_80_3",   4'b1000, 8'h80, 8'h03, 8'hF0, 4'b1000, 1'b0, 1);
    run_vec("lsr_81_1",   4'b1001, 8'h81, 8'h01, 8'h40, 4'b0010, 1'b0, 1);
    run_vec("lsl_01_9",   4'b0111, 8'h01, 8'h09, 8'h02, 4'b0000, 1'b0, 1);
    run_vec("lsl_81_0",   4'b0111, 8'h81, 8'h00, 8'h81, 4'b1000, 1'b0, 1);
    run_vec("asl_40_1",   4'b0110, 8'h40, 8'h01, 8'h80, 4'b1001, 1'b0, 1);
    run_vec("asl_c0_1",   4'b0110, 8'hC0, 8'h01, 8'h80, 4'b1010, 1'b0, 1);
    run_vec("add_7f_01",  4'b0000, 8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0, 1);
    run_vec("not_0f",     4'b0010, 8'h0F, 8'h00, 8'hF0, 4'b1000, 1'b0, 1);
    run_vec("and_f0_3c",  4'b0011, 8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b0, 1);
    run_vec("or_00_00",   4'b0100, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b0, 1);
    run_vec("xor_aa_55",  4'b0101, 8'hAA, 8'h55, 8'hFF, 4'b1000, 1'b0, 1);
    run_vec("illegal_f",  4'b1111, 8'h12, 8'h34, 8'h00, 4'b0100, 1'b1, 1);

    // Backpressure: hold the ADD result for three cycles while a new op is offered.
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; op = 4'b0000; a = 8'h03; b = 8'h04;
    @(negedge clk);
    a = 8'h10; b = 8'h20;
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("stall_out_valid", 32'(out_valid), 32'(1));
      chk("stall_result",    32'(result),    32'(8'h07));
      chk("stall_flags",     32'(flags),     32'(4'b0000));
      chk("stall_in_ready",  32'(in_ready),  32'(0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #2;
    chk("drain_in_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    #2;
    chk("drain_accept_result", 32'(result),    32'(8'h30));
    chk("drain_accept_valid",  32'(out_valid), 32'(1));

    // Back-to-back accepts, one per cycle.
    for (int i = 1; i <= 6; i++) begin
      op = 4'b0000; a = W'(i * 16); b = W'(i);
      #1;
      chk("b2b_in_ready", 32'(in_ready), 32'(1));
      @(negedge clk);
      #2;
      chk("b2b_result", 32'(result), 32'(i * 17));
    end
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("persist_flags_after_drain", 32'(flags), 32'(4'b0000));
    chk("persist_valid_dropped",     32'(out_valid), 32'(0));

    // Reset in the third MUL cycle aborts the multiply.
    run_vec("add_pre_rst", 4'b0000, 8'hFF, 8'h01, 8'h00, 4'b0110, 1'b0, 1);
    in_valid = 1'b1; op = 4'b1010; a = 8'h0C; b = 8'h0B;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2;
    chk("mul_busy_in_ready", 32'(in_ready), 32'(0));
    chk("mul_busy_flags",    32'(flags),    32'(4'b0110));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #2;
    chk("mulrst_out_valid", 32'(out_valid), 32'(0));
    chk("mulrst_flags",     32'(flags),     32'(0));
    chk("mulrst_result",    32'(result),    32'(0));
    rst_n = 1'b1;
    #1;
    chk("mulrst_in_ready",  32'(in_ready),  32'(1));
    repeat (W + 2) @(negedge clk);
    #2;
    chk("mulrst_no_late_result", 32'(out_valid), 32'(0));
    run_vec("illegal_c", 4'b1100, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b1, 1);

    repeat (3) @(negedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
